mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access stage of the multi-cycle MIPS pipeline. Consumes the 154-bit EXE_MEM bus
//  produced by exe, issues load/store to the synchronous data RAM, formats load data.
//  Emits the 118-bit MEM_WB bus to wb. Loads take LOAD_LAT+1 cycles via an FSM; stores and
//  non-memory ops complete in their accept cycle.
// PARAMETERS
//  LOAD_LAT  1  data-RAM read latency in cycles, legal 1..4
//  CNT_W     2  width of the latency counter, must hold LOAD_LAT-1
// PORTS
//  clk            in   1    clock, rising edge
//  resetn         in   1    synchronous, active-low reset
//  MEM_valid      in   1    EXE_MEM_bus_r holds a live instruction
//  EXE_MEM_bus_r  in   154  {mem_control[3:0],store_data[31:0],exe_result[31:0],lo_result[31:0],
//                            hi_write,lo_write,mfhi,mflo,mtc0,mfc0,cp0r_addr[7:0],syscall,eret,
//                            rf_wen,rf_wdest[4:0],pc[31:0]}
//  MEM_over       out  1    instruction finished; MEM_WB_bus valid this cycle
//  MEM_WB_bus     out  118  {rf_wen,rf_wdest,mem_result[31:0],lo_result,hi_write,lo_write,
//                            mfhi,mflo,mtc0,mfc0,cp0r_addr,syscall,eret,pc}
//  dm_addr        out  32   word-aligned RAM address {exe_result[31:2],2'b00}
//  dm_wen         out  4    per-byte write strobe
//  dm_wdata       out  32   RAM write data
//  dm_rdata       in   32   RAM read data, valid LOAD_LAT cycles after address issue
//  MEM_wdest      out  5    rf_wdest if MEM_valid & rf_wen, else 0 (hazard detect)
//  MEM_pc         out  32   pc field of current instruction
// BEHAVIOUR
//  mem_control = {load, store, ls_word, lb_sign}; load&store both set -> treated as load, dm_wen=0.
//  FSM: IDLE, WAIT. Reset: state=IDLE, cnt=0, MEM_over=0, dm_wen=0, dm_addr=dm_wdata=0 only
//  when !MEM_valid. While resetn=0, dm_wen and MEM_over are forced 0 combinationally.
//  IDLE & !MEM_valid: MEM_over=0, dm_wen=0.
//  IDLE & MEM_valid & !load & !store: MEM_over=1 same cycle; mem_result=exe_result.
//  IDLE & MEM_valid & store: exactly one write cycle, MEM_over=1 same cycle.
//   word: dm_wen=4'b1111, dm_wdata=store_data (addr[1:0] ignored).
//   byte: dm_wen=4'b0001<<addr[1:0], dm_wdata={4{store_data[7:0]}}.
//  IDLE & MEM_valid & load: drive dm_addr, dm_wen=0, cnt<=LOAD_LAT-1, go WAIT; MEM_over=0.
//  WAIT & MEM_valid & cnt!=0: cnt<=cnt-1. WAIT & cnt==0: MEM_over=1, capture formatted
//   dm_rdata into mem_result combinationally this cycle, next state IDLE. Load latency is
//   LOAD_LAT cycles after accept (over on cycle t+LOAD_LAT).
//   word: mem_result=dm_rdata.
//   byte: b=dm_rdata[8*addr[1:0]+:8]; lb_sign ? {{24{b[7]}},b} : {24'b0,b}.
//  dm_addr held stable throughout WAIT.
//  WAIT & !MEM_valid (flush): abort, -> IDLE next cycle, MEM_over never asserted for it.
//  Contract: upstream advances to a new instruction (or drops MEM_valid) in the cycle after
//   every MEM_over. Back-to-back loads therefore cost LOAD_LAT+1 cycles each.
//  All other MEM_WB_bus fields pass through unchanged from EXE_MEM_bus_r.
//  resetn low in WAIT: next edge -> IDLE, pending load discarded, no MEM_over.
// TESTING
//  1 LOAD_LAT=1, lw addr 0x10, RAM[0x10]=0xDEADBEEF -> MEM_over 1 cycle after accept,
//    mem_result=0xDEADBEEF, dm_wen=0 throughout.
//  2 lb signed addr 0x13, RAM word 0x80FF_0102 -> mem_result=0xFFFFFF80; lbu same -> 0x00000080.
//  3 sb addr 0x22, store_data=0x123456AB -> dm_wen=4'b0100, dm_wdata=0xABABABAB,
//    MEM_over same cycle; sw addr 0x20 -> dm_wen=4'b1111.
//  4 addu (mem_control=0), exe_result=0x5 -> MEM_over same cycle, mem_result=0x5,
//    MEM_wdest=rf_wdest.
//  5 LOAD_LAT=3, lw then MEM_valid dropped in 2nd WAIT cycle -> no MEM_over,
//    IDLE next cycle; repeat with resetn=0 instead -> same result, dm_wen=0.
//  6 lw, sw, lw back-to-back (LOAD_LAT=2) -> MEM_over at cycles 2,3,6.
//    Exactly one write strobe, passthrough fields bit-exact.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage issuing data-RAM loads/stores and formatting load data
module mem_stage #(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         MEM_valid,
    input  logic [153:0] EXE_MEM_bus_r,
    output logic         MEM_over,
    output logic [117:0] MEM_WB_bus,
    output logic [31:0]  dm_addr,
    output logic [3:0]   dm_wen,
    output logic [31:0]  dm_wdata,
    input  logic [31:0]  dm_rdata,
    output logic [4:0]   MEM_wdest,
    output logic [31:0]  MEM_pc
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;

    logic [3:0]  mem_control;
    logic [31:0] store_data, exe_result, lo_result, pc;
    logic [15:0] misc;
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic        load, store, ls_word, lb_sign;
    logic [1:0]  byte_sel;
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [31:0] load_data, mem_result;

    assign mem_control = EXE_MEM_bus_r[153:150];
    assign store_data  = EXE_MEM_bus_r[149:118];
    assign exe_result  = EXE_MEM_bus_r[117:86];
    assign lo_result   = EXE_MEM_bus_r[85:54];
    assign misc        = EXE_MEM_bus_r[53:38];
    assign rf_wen      = EXE_MEM_bus_r[37];
    assign rf_wdest    = EXE_MEM_bus_r[36:32];
    assign pc          = EXE_MEM_bus_r[31:0];

    // a combined load+store encoding is treated as a pure load
    assign load     = mem_control[3];
    assign store    = mem_control[2] & ~mem_control[3];
    assign ls_word  = mem_control[1];
    assign lb_sign  = mem_control[0];
    assign byte_sel = exe_result[1:0];

    // load data formatting and stage outputs
    always_comb begin
        shifted    = dm_rdata >> {byte_sel, 3'b000};
        b          = shifted[7:0];
        load_data  = ls_word ? dm_rdata : {{24{lb_sign & b[7]}}, b};
        mem_result = load ? load_data : exe_result;
        MEM_over   = resetn & MEM_valid & ((state == IDLE) ? ~load : (cnt == '0));
        dm_wen     = (resetn & MEM_valid & (state == IDLE) & store)
                     ? (ls_word ? 4'b1111 : 4'b0001 << byte_sel) : 4'b0000;
        dm_addr    = MEM_valid ? {exe_result[31:2], 2'b00} : 32'h0;
        dm_wdata   = MEM_valid ? (ls_word ? store_data : {4{store_data[7:0]}}) : 32'h0;
        MEM_wdest  = (MEM_valid & rf_wen) ? rf_wdest : 5'd0;
        MEM_pc     = pc;
        MEM_WB_bus = {rf_wen, rf_wdest, mem_result, lo_result, misc, pc};
    end

    // load-latency FSM; a flush or reset during WAIT discards the pending load
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (state == IDLE) begin
            if (MEM_valid & load) begin
                state <= WAIT;
                cnt   <= CNT_W'(LOAD_LAT - 1);
            end
        end else if (!MEM_valid || cnt == '0) begin
            state <= IDLE;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage at load latencies 1, 2 and 3
module tb_mem_stage;
    logic         clk = 1'b0;
    logic         resetn;
    logic         valid;
    logic [153:0] bus;
    logic         ov1, ov2, ov3;
    logic [117:0] wb1, wb2, wb3;
    logic [31:0]  ad1, ad2, ad3, wd1, wd2, wd3, pc1, pc2, pc3;
    logic [31:0]  rd1, rd2, rd3, r2a, r3a, r3b;
    logic [3:0]   wn1, wn2, wn3;
    logic [4:0]   ds1, ds2, ds3;
    logic [31:0]  mem [64];
    int           cmp = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    mem_stage #(.LOAD_LAT(1), .CNT_W(2)) u1 (.clk(clk), .resetn(resetn), .MEM_valid(valid),
        .EXE_MEM_bus_r(bus), .MEM_over(ov1), .MEM_WB_bus(wb1), .dm_addr(ad1), .dm_wen(wn1),
        .dm_wdata(wd1), .dm_rdata(rd1), .MEM_wdest(ds1), .MEM_pc(pc1));
    mem_stage #(.LOAD_LAT(2), .CNT_W(2)) u2 (.clk(clk), .resetn(resetn), .MEM_valid(valid),
        .EXE_MEM_bus_r(bus), .MEM_over(ov2), .MEM_WB_bus(wb2), .dm_addr(ad2), .dm_wen(wn2),
        .dm_wdata(wd2), .dm_rdata(rd2), .MEM_wdest(ds2), .MEM_pc(pc2));
    mem_stage #(.LOAD_LAT(3), .CNT_W(2)) u3 (.clk(clk), .resetn(resetn), .MEM_valid(valid),
        .EXE_MEM_bus_r(bus), .MEM_over(ov3), .MEM_WB_bus(wb3), .dm_addr(ad3), .dm_wen(wn3),
        .dm_wdata(wd3), .dm_rdata(rd3), .MEM_wdest(ds3), .MEM_pc(pc3));

    // synchronous RAM models with read latency 1, 2 and 3
    always @(posedge clk) begin
        rd1 <= mem[ad1[7:2]];
        r2a <= mem[ad2[7:2]];
        rd2 <= r2a;
        r3a <= mem[ad3[7:2]];
        r3b <= r3a;
        rd3 <= r3b;
    end

    function automatic logic [153:0] mk(logic [3:0] mc, logic [31:0] sd, logic [31:0] er,
                                        logic [4:0] wd, logic [31:0] pc);
        return {mc, sd, er, 32'hCAFEF00D, 16'hB5A6, 1'b1, wd, pc};
    endfunction

    function automatic logic [117:0] ewb(logic [4:0] wd, logic [31:0] mr, logic [31:0] pc);
        return {1'b1, wd, mr, 32'hCAFEF00D, 16'hB5A6, pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        valid  = 1'b1;
        bus    = mk(4'b0110, 32'h11223344, 32'h20, 5'd3, 32'h100);
        tick();
        tick();
        #1;
        cmp++; if ({ov1, ov2, ov3} !== 3'b000) begin bad++; $display("FAIL reset_over got %b want 000", {ov1, ov2, ov3}); end
        cmp++; if ({wn1, wn2, wn3} !== 12'h0) begin bad++; $display("FAIL reset_wen got %h want 000", {wn1, wn2, wn3}); end
        resetn = 1'b1;
        valid  = 1'b0;
        #1;
        cmp++; if (ad1 !== 32'h0 || wd1 !== 32'h0) begin bad++; $display("FAIL idle_addr_wdata got %h/%h want 0/0", ad1, wd1); end
        cmp++; if (ov1 !== 1'b0 || wn1 !== 4'h0) begin bad++; $display("FAIL idle_over_wen got %b/%h want 0/0", ov1, wn1); end
        tick();
    endtask

    task automatic test_lw();
        mem[4] = 32'hDEADBEEF;
        valid  = 1'b1;
        bus    = mk(4'b1010, 32'h0, 32'h10, 5'd9, 32'h200);
        #1;
        cmp++; if (ov1 !== 1'b0 || wn1 !== 4'h0 || ad1 !== 32'h10) begin bad++; $display("FAIL lw_accept got over=%b wen=%h addr=%h want 0/0/10", ov1, wn1, ad1); end
        tick();
        cmp++; if (ov1 !== 1'b1 || wn1 !== 4'h0) begin bad++; $display("FAIL lw_over got over=%b wen=%h want 1/0", ov1, wn1); end
        cmp++; if (wb1 !== ewb(5'd9, 32'hDEADBEEF, 32'h200)) begin bad++; $display("FAIL lw_wb got %h want %h", wb1, ewb(5'd9, 32'hDEADBEEF, 32'h200)); end
        idle();
    endtask

    task automatic test_lb();
        mem[4] = 32'h80FF0102;
        valid  = 1'b1;
        bus    = mk(4'b1001, 32'h0, 32'h13, 5'd4, 32'h300);
        tick();
        cmp++; if (ov1 !== 1'b1 || wb1[111:80] !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_signed got over=%b res=%h want 1/ffffff80", ov1, wb1[111:80]); end
        idle();
        valid = 1'b1;
        bus   = mk(4'b1000, 32'h0, 32'h13, 5'd4, 32'h304);
        tick();
        cmp++; if (ov1 !== 1'b1 || wb1[111:80] !== 32'h00000080) begin bad++; $display("FAIL lbu got over=%b res=%h want 1/00000080", ov1, wb1[111:80]); end
        idle();
        valid = 1'b1;
        bus   = mk(4'b1000, 32'h0, 32'h11, 5'd4, 32'h308);
        tick();
        cmp++; if (wb1[111:80] !== 32'h00000001) begin bad++; $display("FAIL lbu_b1 got %h want 00000001", wb1[111:80]); end
        idle();
    endtask

    task automatic test_store();
        valid = 1'b1;
        bus   = mk(4'b0100, 32'h123456AB, 32'h22, 5'd0, 32'h400);
        #1;
        cmp++; if (wn1 !== 4'b0100 || wd1 !== 32'hABABABAB || ad1 !== 32'h20) begin bad++; $display("FAIL sb got wen=%b data=%h addr=%h want 0100/abababab/20", wn1, wd1, ad1); end
        cmp++; if (ov1 !== 1'b1) begin bad++; $display("FAIL sb_over got %b want 1", ov1); end
        tick();
        bus = mk(4'b0110, 32'h123456AB, 32'h20, 5'd0, 32'h404);
        #1;
        cmp++; if (wn1 !== 4'b1111 || wd1 !== 32'h123456AB || ov1 !== 1'b1) begin bad++; $display("FAIL sw got wen=%b data=%h over=%b want 1111/123456ab/1", wn1, wd1, ov1); end
        tick();
        bus = mk(4'b1110, 32'h123456AB, 32'h20, 5'd0, 32'h408);
        #1;
        cmp++; if (wn1 !== 4'b0000 || ov1 !== 1'b0) begin bad++; $display("FAIL ld_st_both got wen=%b over=%b want 0000/0", wn1, ov1); end
        idle();
    endtask

    task automatic test_alu();
        valid = 1'b1;
        bus   = mk(4'b0000, 32'h0, 32'h5, 5'd7, 32'h500);
        #1;
        cmp++; if (ov1 !== 1'b1 || wb1 !== ewb(5'd7, 32'h5, 32'h500)) begin bad++; $display("FAIL addu got over=%b wb=%h want 1/%h", ov1, wb1, ewb(5'd7, 32'h5, 32'h500)); end
        cmp++; if (ds1 !== 5'd7 || pc1 !== 32'h500 || wn1 !== 4'h0) begin bad++; $display("FAIL addu_wdest got %0d/%h/%h want 7/500/0", ds1, pc1, wn1); end
        bus[37] = 1'b0;
        #1;
        cmp++; if (ds1 !== 5'd0) begin bad++; $display("FAIL wdest_nowen got %0d want 0", ds1); end
        idle();
    endtask

    task automatic test_flush();
        valid = 1'b1;
        bus   = mk(4'b1010, 32'h0, 32'h10, 5'd2, 32'h600);
        tick();
        cmp++; if (ov3 !== 1'b0) begin bad++; $display("FAIL flush_wait1 got %b want 0", ov3); end
        tick();
        valid = 1'b0;
        #1;
        cmp++; if (ov3 !== 1'b0) begin bad++; $display("FAIL flush_wait2 got %b want 0", ov3); end
        tick();
        valid = 1'b1;
        bus   = mk(4'b0110, 32'h55, 32'h24, 5'd0, 32'h604);
        #1;
        cmp++; if (wn3 !== 4'b1111 || ov3 !== 1'b1) begin bad++; $display("FAIL flush_idle got wen=%b over=%b want 1111/1", wn3, ov3); end
        idle();
        valid = 1'b1;
        bus   = mk(4'b1010, 32'h0, 32'h10, 5'd2, 32'h608);
        tick();
        tick();
        resetn = 1'b0;
        #1;
        cmp++; if (ov3 !== 1'b0 || wn3 !== 4'h0) begin bad++; $display("FAIL rst_wait got over=%b wen=%h want 0/0", ov3, wn3); end
        tick();
        resetn = 1'b1;
        bus    = mk(4'b0110, 32'h55, 32'h24, 5'd0, 32'h60C);
        #1;
        cmp++; if (wn3 !== 4'b1111 || ov3 !== 1'b1) begin bad++; $display("FAIL rst_idle got wen=%b over=%b want 1111/1", wn3, ov3); end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [153:0] prog [3];
        logic [117:0] exp_wb [3];
        int           oc [3];
        int           idx = 0;
        int           strobes = 0;
        mem[4]  = 32'h11111111;
        mem[12] = 32'h22222222;
        prog[0] = mk(4'b1010, 32'h0, 32'h10, 5'd5, 32'h700);
        prog[1] = mk(4'b0110, 32'hA5A5A5A5, 32'h34, 5'd6, 32'h704);
        prog[2] = mk(4'b1010, 32'h0, 32'h30, 5'd8, 32'h708);
        exp_wb[0] = ewb(5'd5, 32'h11111111, 32'h700);
        exp_wb[1] = ewb(5'd6, 32'h34, 32'h704);
        exp_wb[2] = ewb(5'd8, 32'h22222222, 32'h708);
        oc = '{-1, -1, -1};
        for (int cyc = 0; cyc < 9; cyc++) begin
            valid = idx < 3;
            if (idx < 3) bus = prog[idx];
            #1;
            if (wn2 !== 4'h0) strobes++;
            if (ov2 === 1'b1 && idx < 3) begin
                oc[idx] = cyc;
                cmp++; if (wb2 !== exp_wb[idx]) begin bad++; $display("FAIL b2b_wb%0d got %h want %h", idx, wb2, exp_wb[idx]); end
                idx++;
            end
            tick();
        end
        cmp++; if (oc[0] != 2 || oc[1] != 3 || oc[2] != 6) begin bad++; $display("FAIL b2b_over_cycles got %0d,%0d,%0d want 2,3,6", oc[0], oc[1], oc[2]); end
        cmp++; if (strobes != 1) begin bad++; $display("FAIL b2b_strobes got %0d want 1", strobes); end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        test_reset();
        test_lw();
        test_lb();
        test_store();
        test_alu();
        test_flush();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
